xoodyak_hash_absorber: RTL and testbench

// Streaming absorb engine for Xoodyak hash mode. It accepts the message as

---
 rtl/xoodyak_hash_absorber.sv | 189 ++++++++++++++++++
 tb/tb_xoodyak_hash_absorber.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xoodyak_hash_absorber.sv
// rtl/xoodyak_hash_absorber.sv - Xoodyak hash-mode streaming absorb engine
//
// Packs BEAT_BYTES-wide message beats into RATE_BYTES blocks, applies Down
// (block, 0x01 pad, Cd on the first block) and requests Up from an external
// XOODOO permutation through a start/done handshake. After the final block
// the 384-bit state is presented for squeezing.
//
// Ports:
//   clk, reset           clock (rising edge), asynchronous active-high reset
//   start, in_empty      begin a new message; in_empty marks a zero-length one
//   in_valid/in_ready    beat handshake; in_data byte k = in_data[8k+7:8k]
//   in_last, in_keep     final beat flag and its valid byte count
//   perm_start           one-cycle permutation request
//   perm_state_o         state offered to the permutation (stable while waiting)
//   perm_state_i         permutation result, valid with perm_done
//   perm_done            one-cycle permutation completion
//   absorb_done          level, high once the message has been absorbed
//   state_out            internal state; byte j = state_out[8j+7:8j]
//   busy                 high outside IDLE and DONE

module xoodyak_hash_absorber #(
  parameter int BEAT_BYTES = 1,
  parameter int RATE_BYTES = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [8*BEAT_BYTES-1:0] in_data,
  input  logic                    in_last,
  input  logic [2:0]              in_keep,
  input  logic                    in_empty,
  output logic                    perm_start,
  output logic [383:0]            perm_state_o,
  input  logic [383:0]            perm_state_i,
  input  logic                    perm_done,
  output logic                    absorb_done,
  output logic [383:0]            state_out,
  output logic                    busy
);

  localparam logic [3:0] BEAT_N = 4'(BEAT_BYTES);
  localparam logic [5:0] RATE_N = 6'(RATE_BYTES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_DOWN,
    S_UP_REQ,
    S_UP_WAIT,
    S_DONE
  } fsm_t;

  fsm_t                    r_fsm;
  fsm_t                    w_fsm_nxt;
  logic [383:0]            r_state;
  logic [8*RATE_BYTES-1:0] r_block;
  logic [5:0]              r_cnt;
  logic                    r_first;
  logic                    r_end;

  logic [3:0]              w_n;
  logic [5:0]              w_cnt_sum;
  logic [383:0]            w_down_state;

  // Bytes carried by the current beat; an out-of-range keep on the last beat
  // falls back to a full beat.
  always_comb begin
    w_n = BEAT_N;
    if (in_last && (in_keep != 3'd0) && ({1'b0, in_keep} <= BEAT_N)) begin
      w_n = {1'b0, in_keep};
    end
  end

  assign w_cnt_sum = r_cnt + {2'b00, w_n};

  // Down: XOR the filled block bytes, then the 0x01 pad right after them,
  // and Cd=0x03 into the last state byte on the first block only.
  always_comb begin
    w_down_state = r_state;
    for (int j = 0; j < RATE_BYTES; j++) begin
      if (j < int'(r_cnt)) begin
        w_down_state[8*j +: 8] = r_state[8*j +: 8] ^ r_block[8*j +: 8];
      end
    end
    for (int j = 0; j < 48; j++) begin
      if (j == int'(r_cnt)) begin
        w_down_state[8*j +: 8] = w_down_state[8*j +: 8] ^ 8'h01;
      end
    end
    if (r_first) begin
      w_down_state[383:376] = w_down_state[383:376] ^ 8'h03;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fsm <= S_IDLE;
    end else begin
      r_fsm <= w_fsm_nxt;
    end
  end

  always_comb begin
    w_fsm_nxt   = r_fsm;
    in_ready    = 1'b0;
    perm_start  = 1'b0;
    absorb_done = 1'b0;
    busy        = 1'b1;
    case (r_fsm)
      S_IDLE: begin
        busy = 1'b0;
        if (start) w_fsm_nxt = in_empty ? S_DOWN : S_FILL;
      end
      S_FILL: begin
        in_ready = 1'b1;
        if (in_valid && ((w_cnt_sum == RATE_N) || in_last)) w_fsm_nxt = S_DOWN;
      end
      S_DOWN: begin
        w_fsm_nxt = r_end ? S_DONE : S_UP_REQ;
      end
      S_UP_REQ: begin
        perm_start = 1'b1;
        w_fsm_nxt  = S_UP_WAIT;
      end
      S_UP_WAIT: begin
        if (perm_done) w_fsm_nxt = S_FILL;
      end
      S_DONE: begin
        busy        = 1'b0;
        absorb_done = 1'b1;
        if (start) w_fsm_nxt = in_empty ? S_DOWN : S_FILL;
      end
      default: w_fsm_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= '0;
      r_block <= '0;
      r_cnt   <= '0;
      r_first <= 1'b0;
      r_end   <= 1'b0;
    end else begin
      case (r_fsm)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state <= '0;
            r_first <= 1'b1;
            r_cnt   <= '0;
            r_end   <= in_empty;
          end
        end
        S_FILL: begin
          if (in_valid) begin
            // cnt is always a multiple of BEAT_BYTES, so the beat never
            // straddles the block boundary.
            for (int j = 0; j < RATE_BYTES; j++) begin
              for (int k = 0; k < BEAT_BYTES; k++) begin
                if ((k < int'(w_n)) && (j == int'(r_cnt) + k)) begin
                  r_block[8*j +: 8] <= in_data[8*k +: 8];
                end
              end
            end
            r_cnt <= w_cnt_sum;
            r_end <= in_last;
          end
        end
        S_DOWN: begin
          r_state <= w_down_state;
          r_first <= 1'b0;
          r_cnt   <= '0;
        end
        S_UP_WAIT: begin
          if (perm_done) r_state <= perm_state_i;
        end
        default: begin
        end
      endcase
    end
  end

  // Cu is zero in hash mode, so Up is just the bare permutation of the state.
  assign perm_state_o = r_state;
  assign state_out    = r_state;

endmodule

// File: tb/tb_xoodyak_hash_absorber.sv
// tb/tb_xoodyak_hash_absorber.sv - self-checking bench for xoodyak_hash_absorber

module tb_xoodyak_hash_absorber;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic         s1_start, s1_valid, s1_ready, s1_last, s1_empty;
  logic [7:0]   s1_data;
  logic [2:0]   s1_keep;
  logic         s1_pstart, s1_adone, s1_busy;
  logic [383:0] s1_pso, s1_state;
  logic [383:0] perm_si;
  logic         perm_done;

  logic         s4_start, s4_valid, s4_ready, s4_last, s4_empty;
  logic [31:0]  s4_data;
  logic [2:0]   s4_keep;
  logic         s4_pstart, s4_adone, s4_busy;
  logic [383:0] s4_pso, s4_state;
  logic [383:0] s4_psi;
  logic         s4_pdone;

  xoodyak_hash_absorber #(.BEAT_BYTES(1), .RATE_BYTES(16)) dut1 (
    .clk(clk), .reset(reset), .start(s1_start), .in_valid(s1_valid),
    .in_ready(s1_ready), .in_data(s1_data), .in_last(s1_last), .in_keep(s1_keep),
    .in_empty(s1_empty), .perm_start(s1_pstart), .perm_state_o(s1_pso),
    .perm_state_i(perm_si), .perm_done(perm_done), .absorb_done(s1_adone),
    .state_out(s1_state), .busy(s1_busy)
  );

  xoodyak_hash_absorber #(.BEAT_BYTES(4), .RATE_BYTES(16)) dut4 (
    .clk(clk), .reset(reset), .start(s4_start), .in_valid(s4_valid),
    .in_ready(s4_ready), .in_data(s4_data), .in_last(s4_last), .in_keep(s4_keep),
    .in_empty(s4_empty), .perm_start(s4_pstart), .perm_state_o(s4_pso),
    .perm_state_i(s4_psi), .perm_done(s4_pdone), .absorb_done(s4_adone),
    .state_out(s4_state), .busy(s4_busy)
  );

  int total = 0;
  int bad = 0;
  logic [7:0]   msg [0:1023];
  logic [383:0] exp_q [$];
  int           expn_q [$];
  int           nperm;
  int           s4_pstarts;
  logic [383:0] first_req;
  logic [383:0] cap;
  int           pcnt;
  bit           pend;
  int           lat_min = 1;
  int           lat_max = 1;

  task automatic chk(input string tag, input logic [383:0] obs, input logic [383:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] rol(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic logic [31:0] rcon(input int r);
    case (r)
      0: return 32'h058;  1: return 32'h038;  2: return 32'h3C0;  3: return 32'h0D0;
      4: return 32'h120;  5: return 32'h014;  6: return 32'h060;  7: return 32'h02C;
      8: return 32'h380;  9: return 32'h0F0; 10: return 32'h1A0; default: return 32'h012;
    endcase
  endfunction

  function automatic logic [383:0] xoodoo(input logic [383:0] s);
    logic [31:0] a [3][4];
    logic [31:0] b [3][4];
    logic [31:0] p [4];
    logic [31:0] e [4];
    logic [31:0] t [4];
    logic [383:0] o;
    for (int y = 0; y < 3; y++)
      for (int x = 0; x < 4; x++) a[y][x] = s[(y*4+x)*32 +: 32];
    for (int r = 0; r < 12; r++) begin
      for (int x = 0; x < 4; x++) p[x] = a[0][x] ^ a[1][x] ^ a[2][x];
      for (int x = 0; x < 4; x++) e[x] = rol(p[(x+3)%4], 5) ^ rol(p[(x+3)%4], 14);
      for (int y = 0; y < 3; y++)
        for (int x = 0; x < 4; x++) a[y][x] = a[y][x] ^ e[x];
      for (int x = 0; x < 4; x++) t[x] = a[1][x];
      for (int x = 0; x < 4; x++) a[1][x] = t[(x+3)%4];
      for (int x = 0; x < 4; x++) a[2][x] = rol(a[2][x], 11);
      a[0][0] = a[0][0] ^ rcon(r);
      for (int y = 0; y < 3; y++)
        for (int x = 0; x < 4; x++) b[y][x] = ~a[(y+1)%3][x] & a[(y+2)%3][x];
      for (int y = 0; y < 3; y++)
        for (int x = 0; x < 4; x++) a[y][x] = a[y][x] ^ b[y][x];
      for (int x = 0; x < 4; x++) a[1][x] = rol(a[1][x], 1);
      for (int x = 0; x < 4; x++) t[x] = a[2][x];
      for (int x = 0; x < 4; x++) a[2][x] = rol(t[(x+2)%4], 8);
    end
    for (int y = 0; y < 3; y++)
      for (int x = 0; x < 4; x++) o[(y*4+x)*32 +: 32] = a[y][x];
    return o;
  endfunction

  // Reference absorb of msg[0..len-1] with a 16-byte rate.
  function automatic logic [383:0] model(input int len);
    logic [383:0] st;
    int pos;
    int blen;
    bit first;
    bit fin;
    st = '0; pos = 0; first = 1'b1; fin = 1'b0;
    while (!fin) begin
      blen = (len - pos > 16) ? 16 : len - pos;
      for (int j = 0; j < blen; j++) st[8*j +: 8] = st[8*j +: 8] ^ msg[pos+j];
      st[8*blen +: 8] = st[8*blen +: 8] ^ 8'h01;
      if (first) st[383:376] = st[383:376] ^ 8'h03;
      first = 1'b0;
      pos = pos + blen;
      if (pos >= len) fin = 1'b1;
      else st = xoodoo(st);
    end
    return st;
  endfunction

  // Permutation responder with random latency; also watches dut4 requests.
  initial begin
    pend = 1'b0; pcnt = 0; nperm = 0; s4_pstarts = 0; perm_done = 1'b0; perm_si = '0;
    forever begin
      @(negedge clk);
      perm_done = 1'b0;
      if (pend) begin
        if (pcnt == 0) begin
          perm_done = 1'b1;
          perm_si = xoodoo(cap);
          pend = 1'b0;
        end else pcnt--;
      end
      if (s1_pstart) begin
        cap = s1_pso;
        if (nperm == 0) first_req = s1_pso;
        nperm++;
        pend = 1'b1;
        pcnt = $urandom_range(lat_min, lat_max) - 1;
      end
      if (s4_pstart) s4_pstarts++;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic beat1(input logic [7:0] d, input logic l);
    int b = 0;
    s1_valid = 1'b1; s1_data = d; s1_last = l; s1_keep = 3'd1;
    while (!s1_ready && b < 3000) begin @(negedge clk); b++; end
    if (b >= 3000) begin
      chk("beat1_timeout", s1_ready, 1);
    end else begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic beat4(input logic [31:0] d, input logic l, input logic [2:0] k);
    int b = 0;
    s4_valid = 1'b1; s4_data = d; s4_last = l; s4_keep = k;
    while (!s4_ready && b < 100) begin @(negedge clk); b++; end
    if (b >= 100) begin
      chk("beat4_timeout", s4_ready, 1);
    end else begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic run1(input int len, input int gap_max);
    exp_q.push_back(model(len));
    expn_q.push_back(len == 0 ? 0 : (len + 15) / 16 - 1);
    nperm = 0;
    @(negedge clk); s1_start = 1'b1; s1_empty = (len == 0);
    @(negedge clk); s1_start = 1'b0; s1_empty = 1'b0;
    for (int i = 0; i < len; i++) begin
      repeat ($urandom_range(0, gap_max)) begin s1_valid = 1'b0; @(negedge clk); end
      beat1(msg[i], i == len - 1);
    end
    s1_valid = 1'b0; s1_last = 1'b0;
  endtask

  task automatic wait_done1(input string tag);
    int b = 0;
    while (!s1_adone && b < 5000) begin @(negedge clk); b++; end
    chk({tag, "_done"}, s1_adone, 1);
    chk({tag, "_state"}, s1_state, exp_q.pop_front());
    chk({tag, "_nperm"}, nperm, expn_q.pop_front());
    chk({tag, "_busy"}, s1_busy, 0);
  endtask

  task automatic wait_done4(input string tag, input logic [383:0] expv);
    int b = 0;
    s4_valid = 1'b0; s4_last = 1'b0;
    while (!s4_adone && b < 100) begin @(negedge clk); b++; end
    chk({tag, "_done"}, s4_adone, 1);
    chk({tag, "_state"}, s4_state, expv);
  endtask

  initial begin
    logic [383:0] e4;
    reset = 1'b1;
    s1_start = 0; s1_valid = 0; s1_data = 0; s1_last = 0; s1_keep = 0; s1_empty = 0;
    s4_start = 0; s4_valid = 0; s4_data = 0; s4_last = 0; s4_keep = 0; s4_empty = 0;
    s4_psi = '0; s4_pdone = 1'b0;
    for (int i = 0; i < 1024; i++) msg[i] = 8'(i);
    repeat (3) @(negedge clk);
    chk("rst_state", s1_state, '0);
    chk("rst_pso", s1_pso, '0);
    chk("rst_ctl", {s1_ready, s1_pstart, s1_adone, s1_busy}, 4'b0000);
    reset = 1'b0;

    // T1: empty message, exact latency
    exp_q.push_back(model(0)); expn_q.push_back(0); nperm = 0;
    @(negedge clk); s1_start = 1'b1; s1_empty = 1'b1;
    @(negedge clk); s1_start = 1'b0; s1_empty = 1'b0;
    chk("t1_down_busy", {s1_busy, s1_adone}, 2'b10);
    @(negedge clk);
    chk("t1_lat", s1_adone, 1);
    wait_done1("t1");
    chk("t1_bytes", {s1_state[383:376], s1_state[7:0]}, 16'h0301);

    // T2: exactly one full block ending on its last beat
    run1(16, 0);
    wait_done1("t2");
    chk("t2_pad", s1_state[135:128], 8'h01);

    // T3: 17 bytes, one permutation
    lat_min = 1; lat_max = 6;
    run1(17, 2);
    wait_done1("t3");
    chk("t3_req", first_req, model(16));

    // T4: 4-byte beats, partial and out-of-range keep on the last beat
    e4 = model(6);
    @(negedge clk); s4_start = 1'b1;
    @(negedge clk); s4_start = 1'b0;
    beat4(32'h03020100, 1'b0, 3'd0);
    beat4(32'hAAAA0504, 1'b1, 3'd2);
    wait_done4("t4", e4);
    e4 = model(8);
    @(negedge clk); s4_start = 1'b1;
    @(negedge clk); s4_start = 1'b0;
    beat4(32'h03020100, 1'b0, 3'd1);
    beat4(32'h07060504, 1'b1, 3'd0);
    wait_done4("t4_keep0", e4);
    @(negedge clk); s4_start = 1'b1;
    @(negedge clk); s4_start = 1'b0;
    beat4(32'h03020100, 1'b0, 3'd2);
    beat4(32'h07060504, 1'b1, 3'd6);
    wait_done4("t4_keep6", e4);
    chk("t4_no_perm", s4_pstarts, 0);

    // T5: long message, random gaps and permutation latency
    lat_min = 1; lat_max = 20;
    run1(1024, 3);
    wait_done1("t5");

    // T6: reset while waiting on the permutation, then a late perm_done
    lat_min = 40; lat_max = 40;
    nperm = 0;
    @(negedge clk); s1_start = 1'b1;
    @(negedge clk); s1_start = 1'b0;
    for (int i = 0; i < 16; i++) beat1(msg[i], 1'b0);
    s1_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6_wait_busy", {s1_busy, s1_ready, s1_adone}, 3'b100);
    chk("t6_req_seen", nperm, 1);
    reset = 1'b1;
    #1;
    chk("t6_rst_now", {s1_busy, s1_state}, '0);
    @(negedge clk); reset = 1'b0;
    repeat (50) @(negedge clk);
    chk("t6_ctl", {s1_ready, s1_pstart, s1_adone, s1_busy}, 4'b0000);
    chk("t6_state", s1_state, '0);
    chk("t6_pso", s1_pso, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
